// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: access-size codes (funct3),
// the LSU state enum, and request legality helpers.
package riscv_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4,
        RESP  = 3'd5
    } lsu_state_t;

    // Unsigned sizes exist only for loads.
    function automatic logic size_legal(input logic [2:0] size, input logic we);
        case (size)
            LS_B, LS_H, LS_W: return 1'b1;
            LS_BU, LS_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LS_H, LS_HU: return off[0];
            LS_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit: byte enables and store data for
// both halves of a (possibly split) access, and load extract/extend.
// The 64-bit views are {second word, first word}; unsplit accesses use only
// the low half.
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [31:0] wdata_rep,
    output logic [63:0] wdata_shift,
    output logic [31:0] rdata_ext
);

    logic [5:0]  lane;
    logic [63:0] rdata_sh;

    assign lane = {1'b0, off, 3'b000};

    // Enable/data generation per size, then extraction and extension of load data.
    always_comb begin
        be          = 8'h00;
        wdata_rep   = wdata;
        wdata_shift = '0;
        rdata_sh    = rdata >> lane;
        rdata_ext   = rdata_sh[31:0];
        case (size)
            LS_B, LS_BU: begin
                be          = 8'h01 << off;
                wdata_rep   = {4{wdata[7:0]}};
                wdata_shift = {56'h0, wdata[7:0]} << lane;
            end
            LS_H, LS_HU: begin
                be          = 8'h03 << off;
                wdata_rep   = {2{wdata[15:0]}};
                wdata_shift = {48'h0, wdata[15:0]} << lane;
            end
            default: begin
                be          = 8'h0F << off;
                wdata_rep   = wdata;
                wdata_shift = {32'h0, wdata} << lane;
            end
        endcase
        case (size)
            LS_B:    rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            LS_BU:   rdata_ext = {24'h0, rdata_sh[7:0]};
            LS_H:    rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            LS_HU:   rdata_ext = {16'h0, rdata_sh[15:0]};
            default: rdata_ext = rdata_sh[31:0];
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns one core memory request into one (or, for a split
// misaligned access, two) word-aligned req/gnt/rvalid bus transactions and
// returns extended load data with a one-cycle done pulse.
// Optional: define LSU_MISALIGNED_SPLIT_EN to split misaligned H/W accesses
// instead of reporting them as errors.
//
// state | meaning
// IDLE  | ready for a new request
// REQ   | first (or only) bus request, held until granted
// WAIT  | waiting for first response
// REQ2  | second word of a split access, held until granted
// WAIT2 | waiting for second response
// RESP  | done pulse, err/rdata valid
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int MEM_ADDR_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [2:0]            data_size_i,
    input  logic [31:0]           addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [MEM_ADDR_W-1:0] mem_addr_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    lsu_state_t  state, state_next;
    logic        we_q, split_q, err_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata1_q, rdata_q;

    logic        accept, req_legal, req_misal, req_err, req_split;
    logic [31:0] word_addr, bus_addr;
    logic [63:0] rdata_cat;
    logic [7:0]  be_all;
    logic [31:0] wdata_rep, rdata_ext;
    logic [63:0] wdata_shift;

    assign accept    = req_valid_i && (state == IDLE);
    assign req_legal = size_legal(data_size_i, we_i);
    assign req_misal = is_misaligned(data_size_i, addr_i[1:0]);
    assign req_err   = !req_legal || (req_misal && !SPLIT_EN);
    assign req_split = SPLIT_EN && req_legal && req_misal;

    // The second word of a split access wraps at the top of the address space.
    assign word_addr = {addr_q[31:2], 2'b00};
    assign rdata_cat = (state == WAIT2) ? {mem_rdata_i, rdata1_q} : {32'h0, mem_rdata_i};

    lsu_align u_align (
        .size        (size_q),
        .off         (addr_q[1:0]),
        .wdata       (wdata_q),
        .rdata       (rdata_cat),
        .be          (be_all),
        .wdata_rep   (wdata_rep),
        .wdata_shift (wdata_shift),
        .rdata_ext   (rdata_ext)
    );

    // State register, request capture and load-data return.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            split_q  <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata1_q <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q    <= we_i;
                size_q  <= data_size_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= req_err;
                split_q <= req_split;
                rdata_q <= '0;
            end
            if (state == WAIT && mem_rvalid_i) begin
                if (split_q) begin
                    rdata1_q <= mem_rdata_i;
                end else if (!we_q) begin
                    rdata_q <= rdata_ext;
                end
            end
            if (state == WAIT2 && mem_rvalid_i && !we_q) begin
                rdata_q <= rdata_ext;
            end
        end
    end

    // Next state and bus/handshake outputs; bus fields are zero when not requesting.
    always_comb begin
        state_next  = state;
        ready_o     = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        bus_addr    = '0;
        mem_be_o    = 4'b0000;
        mem_wdata_o = '0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (req_valid_i) begin
                    state_next = req_err ? RESP : REQ;
                end
            end
            REQ: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                bus_addr    = word_addr;
                mem_be_o    = be_all[3:0];
                mem_wdata_o = split_q ? wdata_shift[31:0] : wdata_rep;
                if (mem_gnt_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_next = split_q ? REQ2 : RESP;
                end
            end
            REQ2: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                bus_addr    = word_addr + 32'd4;
                mem_be_o    = be_all[7:4];
                mem_wdata_o = wdata_shift[63:32];
                if (mem_gnt_i) begin
                    state_next = WAIT2;
                end
            end
            WAIT2: begin
                if (mem_rvalid_i) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                done_o     = 1'b1;
                err_o      = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_addr_o = MEM_ADDR_W'(bus_addr);
    assign rdata_o    = rdata_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-side responder to the decoder's memory controls (we, data_size in funct3 encoding, ALU address, rs2 data). Turns one core load/store request into word-aligned data-memory transactions over a req/gnt/rvalid bus. Produces byte enables and replicated write data, and returns sign- or zero-extended load data to writeback. Sits between the execute stage and data memory; the core stalls while ready_o is low.

Parameters:
- MEM_ADDR_W, 32, width of mem_addr_o; byte address with bits [1:0] always 0.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  core request valid.
- ready_o  out  1  unit idle; request accepted when req_valid_i && ready_o.
- we_i  in  1  1 = store, 0 = load.
- data_size_i  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  byte address from the ALU.
- wdata_i  in  32  rs2 store data.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o; illegal size or misaligned access.
- rdata_o  out  32  extended load data; valid with done_o, held until next accept.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  MEM_ADDR_W  word-aligned address.
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  32  lane-aligned write data.
- mem_gnt_i  in  1  request granted this cycle.
- mem_rvalid_i  in  1  response/ack; carries mem_rdata_i for loads, is the write ack for stores.
- mem_rdata_i  in  32  read word.

Behaviour:
- Reset values: ready_o=1, done_o=0, err_o=0, rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0. State is IDLE.
- FSM states: IDLE, REQ, WAIT, REQ2, WAIT2, RESP.
- IDLE, on accept: capture all request inputs.
  - Illegal size (011, 110, 111), stores of 100/101, or misaligned access: go to RESP with err. No memory traffic.
  - Otherwise go to REQ.
- REQ: mem_req_o=1, holding address, enables, write enable and data stable until mem_gnt_i, then go to WAIT.
- WAIT: wait for mem_rvalid_i. Then go to RESP, or to REQ2 for a split access.
- RESP: done_o=1 for exactly one cycle, then IDLE.
- ready_o=1 only in IDLE.
- mem_rvalid_i outside WAIT/WAIT2 is ignored. Only one transaction is ever outstanding.
- Minimum latency: accept at cycle N, mem_req_o at N+1, gnt at N+1, rvalid at N+2, done_o at N+3.
- Misaligned means: halfword with addr[0]=1, or word with addr[1:0]≠0.
- Let off = addr[1:0] and lane = 8*off.
- Byte enables:
  - B: 0001<<off.
  - H: 0011<<off.
  - W: 1111.
- Store data: B replicates wdata_i[7:0] ×4; H replicates wdata_i[15:0] ×2; W passes through.
- Load: shift mem_rdata_i right by lane, then:
  - B/H: sign-extend from bit 7/15.
  - BU/HU: zero-extend.
  - W: pass through.
- On err, rdata_o=0 and no register write is implied; writeback gating belongs to the core.
- Reset at any state returns to IDLE next edge and drops mem_req_o. A late rvalid after reset is ignored.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned H/W is not an error; it is split into two accesses.
  - First access: word addr&~3, enables 1111<<off (truncated to 4 bits). Path REQ→WAIT.
  - Second access: word (addr&~3)+4, enables for the remaining bytes. Path REQ2→WAIT2→RESP.
  - Store data is shifted left by lane across the 64-bit concatenation {hi, lo}.
  - Load data is {rdata2, rdata1}>>lane, then extended.
  - Word address wrap 0xFFFFFFFC+4 → 0x00000000.
- Undefined: REQ2/WAIT2 are unreachable; misaligned sets err_o with no access.

Decomposition:
- Into riscv_pkg:
  - Size constants LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101.
  - Enum lsu_state_t.
- One sub-module, lsu_align: purely combinational byte-enable/write-data generation and load extract/extend, shared by both access halves.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt same cycle, rvalid next → mem_addr_o=0x100, be=1111, wdata=0xDEADBEEF; done_o at N+3, err_o=0.
- LB addr=0x203, mem_rdata=0x80FF0000 → be=1000, rdata_o=0xFFFFFF80; LBU same → 0x00000080.
- LH addr=0x302, mem_rdata=0x7FFE1234 → rdata_o=0x00007FFE; SH addr=0x302, wdata=0x0000ABCD → be=1100, mem_wdata_o=0xABCDABCD.
- gnt delayed 3 cycles, rvalid delayed 2 more → request signals stable throughout, single done_o pulse, ready_o low until RESP ends; spurious rvalid in IDLE ignored.
- LW addr=0x101:
  - Split disabled → err_o=1, rdata_o=0, mem_req_o never high.
  - Split enabled, words 0x44332211@0x100 and 0x88776655@0x104 → two requests with be 1110 then 0001, rdata_o=0x55443322.
- rst_i asserted during WAIT → next cycle IDLE, mem_req_o=0, ready_o=1; following rvalid produces no done_o.
